// File: rtl/mem_stage_access_pkg.sv
// Shared encodings for the MEM-stage load/store access path: access sizes,
// writeback-select codes, FSM states and the alignment rule.
package mem_stage_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] RW_ALU  = 2'b00;
  localparam logic [1:0] RW_LOAD = 2'b01;
  localparam logic [1:0] RW_PC4  = 2'b10;
  localparam logic [1:0] RW_CMP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Size code 2'b11 behaves as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_access_align.sv
// Combinational lane logic: store byte-lane replication and enables, load
// lane extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import mem_stage_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [3:0]      st_be_o,
  output logic [XLEN-1:0] st_wdata_o,
  output logic            misalign_o,
  input  logic [1:0]      ld_size_i,
  input  logic [1:0]      ld_off_i,
  input  logic            ld_unsigned_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign misalign_o = is_misaligned(st_size_i, st_off_i);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {(XLEN/8){st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {(XLEN/16){st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword lanes sit at offset 0 or 2 once alignment has been enforced.
  assign lane_b = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
  assign lane_h = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{(XLEN-8){~ld_unsigned_i & lane_b[7]}}, lane_b};
      SZ_HALF: ld_data_o = {{(XLEN-16){~ld_unsigned_i & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: issues req/gnt/rvalid data-memory transactions for loads and
// stores, stalls upstream while one is in flight, and registers MEM/WB.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [1:0]        dram_ex_type_i,
  input  logic              dramwe_i,
  input  logic [1:0]        rwsel_i,
  input  logic [REG_AW-1:0] regwr_i,
  input  logic              regwe_i,
  input  logic              compout_i,
  input  logic [XLEN-1:0]   aluout_i,
  input  logic [XLEN-1:0]   dramin_i,
  input  logic              unsigned_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   wb_pc_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              wb_we_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  state_e state_q, state_d;

  logic is_mem, misal, mem_go, mem_bad;
  logic capture, st_done, ld_done, stall_raw;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_data;

  logic              op_we_q, op_uns_q, op_regwe_q, op_cmp_q;
  logic [1:0]        op_size_q, op_off_q, op_rwsel_q;
  logic [XLEN-1:0]   op_pc_q, op_alu_q;
  logic [REG_AW-1:0] op_rd_q;

  logic              req_q, we_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [3:0]        be_q;

  logic              wb_valid_q, wb_we_q, misalign_q;
  logic [XLEN-1:0]   wb_pc_q, wb_data_q;
  logic [REG_AW-1:0] wb_rd_q;

  function automatic logic [XLEN-1:0] wb_sel(input logic [1:0]      rwsel,
                                             input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] pc,
                                             input logic            cmp,
                                             input logic [XLEN-1:0] ld);
    logic [XLEN-1:0] v;
    case (rwsel)
      RW_ALU:  v = alu;
      RW_LOAD: v = ld;
      RW_PC4:  v = pc + XLEN'(4);
      default: v = {{(XLEN-1){1'b0}}, cmp};
    endcase
    return v;
  endfunction

  assign is_mem  = in_valid_i & (dramwe_i | (rwsel_i == RW_LOAD));
  assign mem_go  = is_mem & ~misal;
  assign mem_bad = is_mem & misal;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size_i     (dram_ex_type_i),
    .st_off_i      (aluout_i[1:0]),
    .st_data_i     (dramin_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .misalign_o    (misal),
    .ld_size_i     (op_size_q),
    .ld_off_i      (op_off_q),
    .ld_unsigned_i (op_uns_q),
    .ld_rdata_i    (dmem_rdata_i),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_go)        state_d = ST_REQ;
      ST_REQ:  if (dmem_gnt_i)    state_d = op_we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (dmem_rvalid_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    st_done   = 1'b0;
    ld_done   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture   = mem_go;
        stall_raw = mem_go;
      end
      ST_REQ: begin
        st_done   = dmem_gnt_i & op_we_q;
        stall_raw = ~st_done;
      end
      ST_WAIT: begin
        ld_done   = dmem_rvalid_i;
        stall_raw = ~dmem_rvalid_i;
      end
      default: ;
    endcase
  end

  // Nothing is held upstream while the stage is in reset.
  assign stall_o = rst_n & stall_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      op_we_q    <= 1'b0;
      op_uns_q   <= 1'b0;
      op_regwe_q <= 1'b0;
      op_cmp_q   <= 1'b0;
      op_size_q  <= '0;
      op_off_q   <= '0;
      op_rwsel_q <= '0;
      op_pc_q    <= '0;
      op_alu_q   <= '0;
      op_rd_q    <= '0;
    end else if (capture) begin
      req_q      <= 1'b1;
      we_q       <= dramwe_i;
      addr_q     <= {aluout_i[XLEN-1:2], 2'b00};
      be_q       <= st_be;
      wdata_q    <= st_wdata;
      op_we_q    <= dramwe_i;
      op_uns_q   <= unsigned_i;
      op_regwe_q <= regwe_i;
      op_cmp_q   <= compout_i;
      op_size_q  <= dram_ex_type_i;
      op_off_q   <= aluout_i[1:0];
      op_rwsel_q <= rwsel_i;
      op_pc_q    <= pc_i;
      op_alu_q   <= aluout_i;
      op_rd_q    <= regwr_i;
    end else if ((state_q == ST_REQ) && dmem_gnt_i) begin
      req_q <= 1'b0;
    end
  end

  // wb_valid/misalign are single-cycle pulses; the other wb fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      if ((state_q == ST_IDLE) && !is_mem) begin
        wb_valid_q <= in_valid_i;
        wb_pc_q    <= pc_i;
        wb_rd_q    <= regwr_i;
        wb_we_q    <= in_valid_i & regwe_i;
        wb_data_q  <= wb_sel(rwsel_i, aluout_i, pc_i, compout_i, '0);
      end else if ((state_q == ST_IDLE) && mem_bad) begin
        wb_valid_q <= 1'b1;
        wb_pc_q    <= pc_i;
        wb_rd_q    <= regwr_i;
        wb_we_q    <= 1'b0;
        wb_data_q  <= aluout_i;
        misalign_q <= 1'b1;
      end else if (st_done || ld_done) begin
        wb_valid_q <= 1'b1;
        wb_pc_q    <= op_pc_q;
        wb_rd_q    <= op_rd_q;
        wb_we_q    <= op_regwe_q;
        wb_data_q  <= wb_sel(op_rwsel_q, op_alu_q, op_pc_q, op_cmp_q, ld_data);
      end
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_pc_o      = wb_pc_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_we_o      = wb_we_q;
  assign wb_data_o    = wb_data_q;
  assign misalign_o   = misalign_q;

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. Sits between EX/MEM and MEM/WB in the 5-stage RISC-V core.
- Turns load/store control (store enable, access type, unsigned flag, address, store data) into a req/gnt/rvalid transaction on the data-memory port.
- Aligns and extends load data, selects the writeback value, and registers the MEM/WB fields.
- Stalls upstream stages while a memory transaction is in flight.

Parameters:
- XLEN, 32, data/address width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- pc_i  in  XLEN  instruction PC
- dram_ex_type_i  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word)
- dramwe_i  in  1  store
- rwsel_i  in  2  writeback select: 00 ALU, 01 load data, 10 pc+4, 11 compare bit
- regwr_i  in  REG_AW  destination register
- regwe_i  in  1  register write enable
- compout_i  in  1  compare result
- aluout_i  in  XLEN  ALU result / effective address
- dramin_i  in  XLEN  store data, low-aligned
- unsigned_i  in  1  zero-extend loads when 1
- stall_o  out  1  hold EX/MEM and earlier stages (combinational)
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  request is write
- dmem_addr_o  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  XLEN  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  XLEN  read word
- wb_valid_o  out  1  MEM/WB slot valid
- wb_pc_o  out  XLEN  PC to WB
- wb_rd_o  out  REG_AW  destination to WB
- wb_we_o  out  1  register write to WB
- wb_data_o  out  XLEN  writeback value
- misalign_o  out  1  one-cycle misaligned-access flag

Behaviour:
- Reset: state IDLE; every output register 0 (dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, all wb_*, misalign_o).
- Reset mid-transaction aborts it; dmem_req_o drops immediately with rst_n.
- Mem op = in_valid_i & (dramwe_i | rwsel_i==01) & aligned.
- Alignment rules:
  - half requires addr[0]==0
  - word requires addr[1:0]==0
  - byte is always aligned
- FSM, state IDLE:
  - Non-mem or bubble: wb_* loaded at next edge (1-cycle latency); wb_valid_o = in_valid_i; no stall.
  - Misaligned mem op: no request issued; next edge wb_valid_o=1, wb_we_o=0, misalign_o=1 for one cycle; no stall.
  - Aligned mem op: stall_o=1; latch op into internal regs; at the edge assert dmem_req_o plus addr/be/wdata/we; go REQ.
- FSM, state REQ:
  - dmem_req_o held with stable fields until dmem_gnt_i.
  - On gnt, store: done this cycle; stall_o=0; next edge wb_valid_o=1 with regwe as latched; go IDLE.
  - On gnt, load: go WAIT; dmem_req_o deasserts at the edge.
- FSM, state WAIT:
  - Wait for dmem_rvalid_i; rvalid is never asserted in the same cycle as gnt.
  - On rvalid: stall_o=0; next edge wb_data_o = extended load; wb_valid_o=1; go IDLE.
- stall_o = (IDLE & aligned mem op) | (REQ & ~(gnt & store)) | (WAIT & ~rvalid).
- Inputs are held stable by upstream while stall_o=1.
- On return to IDLE, the held instruction is not re-captured: capture is qualified by state==IDLE at the sampling edge.
- wb_valid_o=0 on every cycle in which no instruction completes, including stall cycles.
- Minimum latency: store 2 cycles, load 3 cycles, measured from presentation to wb_valid_o.
- Store lane mapping (off = addr[1:0]):
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<off
  - half: wdata={2{d[15:0]}}, be=4'b0011<<off
  - word: wdata=d, be=4'b1111
- Load extraction:
  - Select the lane from rdata >> (8*off).
  - Byte/half are sign-extended, or zero-extended when unsigned_i=1; word is passed through.
- Writeback select:
  - 00: aluout
  - 01: load result
  - 10: pc+4 (mod 2^XLEN)
  - 11: {31'b0, compout}

Decomposition:
- Shared package holds:
  - access-size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - RWSel encodings
  - FSM state enum (IDLE/REQ/WAIT)
- Sub-module lsu_align (combinational): store lane replication/byte enables, load extraction/extension, misalign detect.
- FSM and wb registers live in mem_stage_access.

Test Plan:
- Reset during WAIT with a load outstanding -> dmem_req_o=0, stall_o=0, wb_valid_o=0 immediately; IDLE afterwards.
- ALU op rwsel=00, aluout=0x1234 -> next cycle wb_valid_o=1, wb_data_o=0x1234, stall_o never high.
- Store byte addr=0x103, d=0xAB, gnt delayed 2 cycles -> dmem_be_o=1000, dmem_wdata_o=0xABABABAB, dmem_addr_o=0x100 stable while waiting; stall_o high 3 cycles; wb_valid_o 1 cycle after gnt.
- Load half addr=0x202, rdata=0x8001_7FFF, unsigned=0 -> wb_data_o=0xFFFF8001; repeat with unsigned=1 -> 0x00008001.
- Load word addr=0x206 -> no dmem_req_o; misalign_o=1 for one cycle; wb_we_o=0; no stall.
- Back-to-back load then ALU op -> ALU result appears exactly one cycle after load writeback; held load is issued once (single dmem_req_o/gnt pair).
